// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU execute-to-memory result stage:
//   - rstatus exception codes carried alongside each ALU op
//   - state encoding of the result-stage skid buffer
//   - entry record {result, rd, wen} at the default datapath width
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 32;
    localparam int unsigned RD_W      = 5;

    // rstatus codes; EXC_NONE marks an op that can never raise
    localparam logic [2:0] EXC_NONE = 3'd0;
    localparam logic [2:0] EXC_ADD  = 3'd1;
    localparam logic [2:0] EXC_ADDI = 3'd2;
    localparam logic [2:0] EXC_SUB  = 3'd3;
    localparam logic [2:0] EXC_MUL  = 3'd4;
    localparam logic [2:0] EXC_DIV  = 3'd5;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } stage_state_t;

    typedef struct packed {
        logic [ALU_WIDTH-1:0] result;
        logic [RD_W-1:0]      rd;
        logic                 wen;
    } alu_entry_t;

endpackage

// File: rtl/alu_stage_skid.sv
// -----------------------------------------------------------------------------
// alu_stage_skid
// Two-entry skid buffer (head + skid) with a three-state occupancy FSM operating
// on an opaque packed entry. in_ready and out_valid are both registered, so the
// upstream ready never depends combinationally on out_ready.
// Ports:
//   clock, reset (sync, active-low), flush (sync kill of all entries)
//   in_valid/in_ready/in_data     upstream handshake and entry
//   out_valid/out_ready/out_data  downstream handshake and head entry
// -----------------------------------------------------------------------------
module alu_stage_skid
    import alu_pkg::*;
#(
    parameter int unsigned ENTRY_W = 38
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [ENTRY_W-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ENTRY_W-1:0] out_data
);

    stage_state_t       state_r;
    stage_state_t       state_nxt_s;
    logic [ENTRY_W-1:0] head_r;
    logic [ENTRY_W-1:0] head_nxt_s;
    logic [ENTRY_W-1:0] skid_r;
    logic [ENTRY_W-1:0] skid_nxt_s;
    logic               in_ready_r;
    logic               out_valid_r;
    logic               accept_s;
    logic               pop_s;

    assign accept_s  = in_valid && in_ready_r;
    assign pop_s     = out_valid_r && out_ready;
    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = head_r;

    // Next-state and next-contents of the head/skid slots; flush overrides everything
    always_comb begin
        state_nxt_s = state_r;
        head_nxt_s  = head_r;
        skid_nxt_s  = skid_r;
        if (flush) begin
            state_nxt_s = ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        head_nxt_s  = in_data;
                        state_nxt_s = ST_ONE;
                    end else begin
                        state_nxt_s = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s && pop_s) begin
                        head_nxt_s  = in_data;
                        state_nxt_s = ST_ONE;
                    end else if (accept_s) begin
                        skid_nxt_s  = in_data;
                        state_nxt_s = ST_TWO;
                    end else if (pop_s) begin
                        state_nxt_s = ST_EMPTY;
                    end else begin
                        state_nxt_s = ST_ONE;
                    end
                end
                ST_TWO: begin
                    // in_ready is low here, so only a pop can move the FSM
                    if (pop_s) begin
                        head_nxt_s  = skid_r;
                        state_nxt_s = ST_ONE;
                    end else begin
                        state_nxt_s = ST_TWO;
                    end
                end
                default: begin
                    state_nxt_s = ST_EMPTY;
                end
            endcase
        end
    end

    // State, slot and handshake registers; ready/valid decoded from the next state
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r     <= ST_EMPTY;
            head_r      <= {ENTRY_W{1'b0}};
            skid_r      <= {ENTRY_W{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            head_r      <= head_nxt_s;
            skid_r      <= skid_nxt_s;
            in_ready_r  <= (state_nxt_s != ST_TWO);
            out_valid_r <= (state_nxt_s != ST_EMPTY);
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// -----------------------------------------------------------------------------
// alu_result_stage
// Execute-to-memory boundary stage. Captures the ALU result, destination and
// write enable, rewriting an overflowing op that carries a non-zero rstatus code
// into a write of that code to RSTATUS_REG. Entries leave through a registered
// valid/ready skid buffer (alu_stage_skid).
// Optional feature macro: ALU_STAGE_PERF_EN adds a saturating exc_count of
// accepted rewrite-firing entries (cleared only by reset).
// Ports:
//   clock, reset (sync, active-low), flush (kill buffered entries)
//   in_valid/in_ready, in_result, in_overflow, in_exc_code, in_rd, in_wen
//   out_valid/out_ready, out_result, out_rd, out_wen
//   exc_count (ALU_STAGE_PERF_EN only)
// -----------------------------------------------------------------------------
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH       = ALU_WIDTH,
    parameter int unsigned RSTATUS_REG = 30
`ifdef ALU_STAGE_PERF_EN
    ,parameter int unsigned CNT_W      = 16
`endif
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic             in_overflow,
    input  logic [2:0]       in_exc_code,
    input  logic [4:0]       in_rd,
    input  logic             in_wen,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [4:0]       out_rd,
    output logic             out_wen
`ifdef ALU_STAGE_PERF_EN
    ,output logic [CNT_W-1:0] exc_count
`endif
);

    localparam int unsigned ENTRY_W = WIDTH + 6;

    logic               fire_s;
    logic [WIDTH-1:0]   cap_result_s;
    logic [4:0]         cap_rd_s;
    logic               cap_wen_s;
    logic [ENTRY_W-1:0] cap_entry_s;
    logic [ENTRY_W-1:0] head_entry_s;

    // Ops whose code is EXC_NONE pass through even when overflow is flagged
    assign fire_s = in_overflow && (in_exc_code != EXC_NONE);

    // Overflow->rstatus rewrite applied on the way into the buffer
    always_comb begin
        cap_result_s = in_result;
        cap_rd_s     = in_rd;
        cap_wen_s    = in_wen;
        if (fire_s) begin
            cap_result_s = {{(WIDTH-3){1'b0}}, in_exc_code};
            cap_rd_s     = 5'(RSTATUS_REG);
            cap_wen_s    = 1'b1;
        end else begin
            cap_result_s = in_result;
            cap_rd_s     = in_rd;
            cap_wen_s    = in_wen;
        end
    end

    assign cap_entry_s = {cap_result_s, cap_rd_s, cap_wen_s};

    alu_stage_skid #(
        .ENTRY_W (ENTRY_W)
    ) u_skid (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (cap_entry_s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (head_entry_s)
    );

    assign out_result = head_entry_s[ENTRY_W-1:6];
    assign out_rd     = head_entry_s[5:1];
    assign out_wen    = head_entry_s[0];

`ifdef ALU_STAGE_PERF_EN
    logic [CNT_W-1:0] exc_count_r;
    logic             count_s;

    // A flushed same-cycle capture never enters the buffer, so it is not counted
    assign count_s   = in_valid && in_ready && !flush && fire_s;
    assign exc_count = exc_count_r;

    // Saturating exception counter; flush deliberately leaves it untouched
    always_ff @(posedge clock) begin
        if (!reset) begin
            exc_count_r <= {CNT_W{1'b0}};
        end else if (count_s && (exc_count_r != {CNT_W{1'b1}})) begin
            exc_count_r <= exc_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            exc_count_r <= exc_count_r;
        end
    end
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
module tb_alu_result_stage;
    import alu_pkg::*;

    logic        clock;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic        in_overflow;
    logic [2:0]  in_exc_code;
    logic [4:0]  in_rd;
    logic        in_wen;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_wen;
`ifdef ALU_STAGE_PERF_EN
    logic [3:0]  exc_count;
`endif

    int tests_run;
    int tests_failed;

`ifdef ALU_STAGE_PERF_EN
    alu_result_stage #(.WIDTH(32), .RSTATUS_REG(30), .CNT_W(4)) dut (
`else
    alu_result_stage #(.WIDTH(32), .RSTATUS_REG(30)) dut (
`endif
        .clock       (clock),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_result   (in_result),
        .in_overflow (in_overflow),
        .in_exc_code (in_exc_code),
        .in_rd       (in_rd),
        .in_wen      (in_wen),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_rd      (out_rd),
        .out_wen     (out_wen)
`ifdef ALU_STAGE_PERF_EN
        ,.exc_count  (exc_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // advance one edge, then settle 1ns past it before anything is sampled
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] res, input logic ovf,
                         input logic [2:0] code, input logic [4:0] rd, input logic wen);
        in_valid    = v;
        in_result   = res;
        in_overflow = ovf;
        in_exc_code = code;
        in_rd       = rd;
        in_wen      = wen;
    endtask

    task automatic check_out(input string tag, input logic [31:0] res,
                             input logic [4:0] rd, input logic wen);
        check_eq({tag, "_valid"},  {63'd0, out_valid}, 64'd1);
        check_eq({tag, "_result"}, {32'd0, out_result}, {32'd0, res});
        check_eq({tag, "_rd"},     {59'd0, out_rd}, {59'd0, rd});
        check_eq({tag, "_wen"},    {63'd0, out_wen}, {63'd0, wen});
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b0;
        flush        = 1'b0;
        out_ready    = 1'b1;
        drive(1'b1, 32'hCAFE_0001, 1'b0, 3'd0, 5'd3, 1'b1);

        // 1: reset held two cycles with in_valid high
        step();
        step();
        check_eq("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check_eq("rst_in_ready",  {63'd0, in_ready}, 64'd1);
        check_eq("rst_result",    {32'd0, out_result}, 64'd0);
        check_eq("rst_rd",        {59'd0, out_rd}, 64'd0);
        check_eq("rst_wen",       {63'd0, out_wen}, 64'd0);
`ifdef ALU_STAGE_PERF_EN
        check_eq("rst_exc_count", {60'd0, exc_count}, 64'd0);
`endif
        drive(1'b0, 32'd0, 1'b0, 3'd0, 5'd0, 1'b0);
        reset = 1'b1;
        step();
        check_eq("idle_out_valid", {63'd0, out_valid}, 64'd0);

        // 2: single entry, then 8 back-to-back
        drive(1'b1, 32'h0000_00FF, 1'b0, 3'd0, 5'd5, 1'b1);
        step();
        check_out("single", 32'h0000_00FF, 5'd5, 1'b1);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'h100 + 32'(i), 1'b0, 3'd0, 5'(i + 1), i[0]);
            step();
            check_out($sformatf("stream%0d", i), 32'h100 + 32'(i), 5'(i + 1), i[0]);
            check_eq($sformatf("stream%0d_rdy", i), {63'd0, in_ready}, 64'd1);
        end
        drive(1'b0, 32'd0, 1'b0, 3'd0, 5'd0, 1'b0);
        step();
        check_eq("drain_valid", {63'd0, out_valid}, 64'd0);

        // 3: overflow rewrite, and overflow with code 0 passing through
        drive(1'b1, 32'h1234_5678, 1'b1, EXC_SUB, 5'd7, 1'b0);
        step();
        check_out("rewrite", 32'd3, 5'd30, 1'b1);
        drive(1'b1, 32'hDEAD_BEEF, 1'b1, EXC_NONE, 5'd9, 1'b0);
        step();
        check_out("ovf_nocode", 32'hDEAD_BEEF, 5'd9, 1'b0);
`ifdef ALU_STAGE_PERF_EN
        check_eq("count_one", {60'd0, exc_count}, 64'd1);
`endif
        drive(1'b0, 32'd0, 1'b0, 3'd0, 5'd0, 1'b0);
        step();

        // 4: back-pressure fills the skid, C is held off, then all drain in order
        out_ready = 1'b0;
        drive(1'b1, 32'hAAAA_0000, 1'b0, 3'd0, 5'd1, 1'b1);
        step();
        check_eq("bp_rdy_after_a", {63'd0, in_ready}, 64'd1);
        drive(1'b1, 32'hBBBB_0000, 1'b0, 3'd0, 5'd2, 1'b1);
        step();
        check_eq("bp_rdy_after_b", {63'd0, in_ready}, 64'd0);
        drive(1'b1, 32'hCCCC_0000, 1'b0, 3'd0, 5'd4, 1'b0);
        step();
        step();
        check_eq("bp_c_held_off", {63'd0, in_ready}, 64'd0);
        check_out("bp_hold_a", 32'hAAAA_0000, 5'd1, 1'b1);
        out_ready = 1'b1;
        step();
        check_out("bp_b", 32'hBBBB_0000, 5'd2, 1'b1);
        check_eq("bp_rdy_reopen", {63'd0, in_ready}, 64'd1);
        step();
        check_out("bp_c", 32'hCCCC_0000, 5'd4, 1'b0);
        drive(1'b0, 32'd0, 1'b0, 3'd0, 5'd0, 1'b0);
        step();
        check_eq("bp_empty", {63'd0, out_valid}, 64'd0);

        // 5: flush in TWO with a same-cycle offer
        out_ready = 1'b0;
        drive(1'b1, 32'h0D0D_0000, 1'b0, 3'd0, 5'd11, 1'b1);
        step();
        drive(1'b1, 32'h0E0E_0000, 1'b0, 3'd0, 5'd12, 1'b1);
        step();
        check_eq("fl_full", {63'd0, in_ready}, 64'd0);
        step();
        check_eq("fl_still_full", {63'd0, in_ready}, 64'd0);
        flush = 1'b1;
        drive(1'b1, 32'h0F0F_0000, 1'b1, EXC_ADD, 5'd13, 1'b1);
        step();
        check_eq("fl_out_valid", {63'd0, out_valid}, 64'd0);
        check_eq("fl_in_ready",  {63'd0, in_ready}, 64'd1);
        // flush also kills an offer made while ready, F offered again now
        step();
        flush = 1'b0;
        drive(1'b0, 32'd0, 1'b0, 3'd0, 5'd0, 1'b0);
        out_ready = 1'b1;
        step();
        check_eq("fl_dropped", {63'd0, out_valid}, 64'd0);
`ifdef ALU_STAGE_PERF_EN
        check_eq("fl_not_counted", {60'd0, exc_count}, 64'd1);

        // 6: saturation at 15, kept by flush, cleared by reset
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 32'(i), 1'b1, EXC_MUL, 5'd2, 1'b0);
            step();
        end
        drive(1'b0, 32'd0, 1'b0, 3'd0, 5'd0, 1'b0);
        check_out("perf_last", 32'd4, 5'd30, 1'b1);
        check_eq("perf_sat", {60'd0, exc_count}, 64'd15);
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        check_eq("perf_flush_keep", {60'd0, exc_count}, 64'd15);
        reset = 1'b0;
        step();
        reset = 1'b1;
        check_eq("perf_reset", {60'd0, exc_count}, 64'd0);
`endif

        // reset mid-transfer discards a full buffer
        out_ready = 1'b0;
        drive(1'b1, 32'h5555_5555, 1'b0, 3'd0, 5'd6, 1'b1);
        step();
        step();
        drive(1'b0, 32'd0, 1'b0, 3'd0, 5'd0, 1'b0);
        reset = 1'b0;
        step();
        reset = 1'b1;
        check_eq("midrst_valid",  {63'd0, out_valid}, 64'd0);
        check_eq("midrst_ready",  {63'd0, in_ready}, 64'd1);
        check_eq("midrst_result", {32'd0, out_result}, 64'd0);
        out_ready = 1'b1;
        step();
        check_eq("midrst_no_ghost", {63'd0, out_valid}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
